// File: rtl/mca_folded_term_adder.sv
// Purpose: signed sum of all K*N +/-H coefficient terms, LANES terms per clock via registered tree + wide accumulator.
// Latency: C+2 cycles from accepted start to sample_valid, C = ceil(K*N/LANES); one sample per C+2 cycles.
// Backpressure: none; start is only honoured while busy=0 and is dropped, not queued, otherwise.
// Optional feature: define MCA_SATURATE_EN to clamp the output to WIDTH_OUT and flag overflow; otherwise wrap.
module mca_folded_term_adder #(
    parameter int K                 = 256,
    parameter int N                 = 8,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int LANES             = 16,
    parameter int OUT_SHIFT         = 0,
    parameter int WIDTH_OUT         = 32
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [K-1:0][N-1:0][WIDTH_COEFFICIENT-1:0] H_matrix,
    input  logic [N-1:0][K-1:0]                        S_matrix,
    output logic                                       busy,
    output logic                                       sample_valid,
    output logic signed [WIDTH_OUT-1:0]                sample,
    output logic                                       overflow
);

    localparam int TERMS     = K * N;
    localparam int WIDTH_ACC = WIDTH_COEFFICIENT + $clog2(TERMS) + 1;
    localparam int C         = (TERMS + LANES - 1) / LANES;
    localparam int CW        = (C > 1) ? $clog2(C) : 1;
    localparam int ROWS      = 1 << CW;
    // one guard bit above the wider of accumulator/output so the range check always has a sign bit to compare
    localparam int WW        = ((WIDTH_ACC > WIDTH_OUT) ? WIDTH_ACC : WIDTH_OUT) + 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(C - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE} state_t;

    state_t                                        state_q, state_d;
    logic [CW-1:0]                                 cnt_q, cnt_d;
    logic [TERMS-1:0]                              s_snap_q, s_snap_d, s_flat_in;
    logic [WIDTH_ACC-1:0]                          tree_q, tree_d;
    logic                                          tree_vld_q, tree_vld_d;
    logic [WIDTH_ACC-1:0]                          acc_q, acc_d;
    logic                                          sample_vld_q, sample_vld_d;
    logic [WIDTH_OUT-1:0]                          sample_q, sample_d;
    logic                                          ovf_q, ovf_d;
    logic                                          accept;

    logic [ROWS-1:0][LANES-1:0][WIDTH_COEFFICIENT-1:0] h_rows;
    logic [ROWS-1:0][LANES-1:0]                        s_rows;
    logic [LANES-1:0][WIDTH_COEFFICIENT-1:0]           h_sel;
    logic [LANES-1:0]                                  s_sel;
    logic [WIDTH_ACC-1:0]                              coef_ext;
    logic [WIDTH_ACC-1:0]                              y;
    logic [WW-1:0]                                     y_wide;
    logic [WIDTH_OUT-1:0]                              y_out;
    logic                                              y_ovf;

    // Flatten control bits to term order t = k*N + n; S_matrix is indexed [n][k].
    for (genvar gk = 0; gk < K; gk++) begin : g_sk
        for (genvar gn = 0; gn < N; gn++) begin : g_sn
            assign s_flat_in[gk*N + gn] = S_matrix[gn][gk];
        end
    end

    // Lay terms out as rows of LANES; slots past K*N are zero coefficients, contributing nothing.
    for (genvar g = 0; g < ROWS; g++) begin : g_row
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int T = g * LANES + l;
            if (T < TERMS) begin : g_term
                assign h_rows[g][l] = H_matrix[T / N][T % N];
                assign s_rows[g][l] = s_snap_q[T];
            end else begin : g_pad
                assign h_rows[g][l] = '0;
                assign s_rows[g][l] = 1'b0;
            end
        end
    end

    // Adder tree: signed sum of the current group's LANES terms, registered into tree_q.
    always_comb begin
        h_sel    = h_rows[cnt_q];
        s_sel    = s_rows[cnt_q];
        tree_d   = '0;
        coef_ext = '0;
        for (int l = 0; l < LANES; l++) begin
            coef_ext = {{(WIDTH_ACC-WIDTH_COEFFICIENT){h_sel[l][WIDTH_COEFFICIENT-1]}}, h_sel[l]};
            if (s_sel[l]) tree_d = tree_d + coef_ext;
            else          tree_d = tree_d - coef_ext;
        end
    end

    assign tree_vld_d = (state_q == ST_ACCUM);

    // Output scaling and reduction to WIDTH_OUT: clamp with overflow flag, or plain two's-complement wrap.
    always_comb begin
        y      = $signed(acc_q) >>> OUT_SHIFT;
        y_wide = {{(WW-WIDTH_ACC){y[WIDTH_ACC-1]}}, y};
        y_out  = WIDTH_OUT'(y_wide);
        y_ovf  = 1'b0;
`ifdef MCA_SATURATE_EN
        if (!(&y_wide[WW-1:WIDTH_OUT-1] || ~|y_wide[WW-1:WIDTH_OUT-1])) begin
            y_ovf = 1'b1;
            y_out = y_wide[WW-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end
`endif
    end

    // Sequencing: IDLE -> ACCUM (C groups) -> DRAIN (last tree into acc) -> DONE (emit, may restart).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s_snap_d     = s_snap_q;
        acc_d        = acc_q;
        sample_vld_d = 1'b0;
        sample_d     = sample_q;
        ovf_d        = ovf_q;
        accept       = 1'b0;
        if (tree_vld_q) acc_d = acc_q + tree_q;
        case (state_q)
            ST_IDLE:  accept = start;
            ST_ACCUM: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_GRP) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  begin
                sample_vld_d = 1'b1;
                sample_d     = y_out;
                ovf_d        = y_ovf;
                state_d      = ST_IDLE;
                accept       = start;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d  = ST_ACCUM;
            cnt_d    = '0;
            s_snap_d = s_flat_in;
            acc_d    = '0;
        end
    end

    // State registers; reset aborts any computation in flight and clears the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s_snap_q     <= '0;
            tree_q       <= '0;
            tree_vld_q   <= 1'b0;
            acc_q        <= '0;
            sample_vld_q <= 1'b0;
            sample_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_snap_q     <= s_snap_d;
            tree_q       <= tree_d;
            tree_vld_q   <= tree_vld_d;
            acc_q        <= acc_d;
            sample_vld_q <= sample_vld_d;
            sample_q     <= sample_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy         = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign sample_valid = sample_vld_q;
    assign sample       = sample_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_mca_folded_term_adder.sv
// Purpose: directed bench for mca_folded_term_adder over four parameterisations, scoreboard of expected samples.
// Latency: expected valid cycle = accept edge + C + 2, checked per sample.
// Backpressure: start pulses during busy must be dropped; any unscored sample_valid is flagged.
module tb_mca_folded_term_adder;

    localparam int CA = 2;    // K=4, N=2, LANES=4
    localparam int CB = 3;    // K=4, N=3, LANES=5
    localparam int CD = 128;  // defaults

    typedef struct {
        longint s;
        bit     o;
        int     cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                     start_a, busy_a, vld_a, ovf_a;
    logic [3:0][1:0][31:0]    H_a;
    logic [1:0][3:0]          S_a;
    logic [31:0]              smp_a;
    logic                     start_b, busy_b, vld_b, ovf_b;
    logic [3:0][2:0][31:0]    H_b;
    logic [2:0][3:0]          S_b;
    logic [31:0]              smp_b;
    logic                     start_c, busy_c, vld_c, ovf_c;
    logic [3:0][1:0][31:0]    H_c;
    logic [1:0][3:0]          S_c;
    logic [7:0]               smp_c;
    logic                     start_d, busy_d, vld_d, ovf_d;
    logic [255:0][7:0][31:0]  H_d;
    logic [7:0][255:0]        S_d;
    logic [31:0]              smp_d;

    exp_t q_a[$], q_b[$], q_c[$], q_d[$];
    exp_t e_a, e_b, e_c, e_d;

    mca_folded_term_adder #(.K(4), .N(2), .LANES(4)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .H_matrix(H_a), .S_matrix(S_a),
        .busy(busy_a), .sample_valid(vld_a), .sample(smp_a), .overflow(ovf_a));
    mca_folded_term_adder #(.K(4), .N(3), .LANES(5)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .H_matrix(H_b), .S_matrix(S_b),
        .busy(busy_b), .sample_valid(vld_b), .sample(smp_b), .overflow(ovf_b));
    mca_folded_term_adder #(.K(4), .N(2), .LANES(4), .WIDTH_OUT(8)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .H_matrix(H_c), .S_matrix(S_c),
        .busy(busy_c), .sample_valid(vld_c), .sample(smp_c), .overflow(ovf_c));
    mca_folded_term_adder #(.OUT_SHIFT(4)) u_d (
        .clk(clk), .reset(reset), .start(start_d), .H_matrix(H_d), .S_matrix(S_d),
        .busy(busy_d), .sample_valid(vld_d), .sample(smp_d), .overflow(ovf_d));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference reduction: arithmetic shift, then clamp (saturating build) or wrap to w bits.
    function automatic exp_t mk(input longint sum, input int shift, input int w, input int c);
        exp_t   e;
        longint y, mx, mn;
        y   = sum >>> shift;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        e.o = 1'b0;
        e.s = y;
`ifdef MCA_SATURATE_EN
        if (y > mx) begin e.s = mx; e.o = 1'b1; end
        else if (y < mn) begin e.s = mn; e.o = 1'b1; end
`endif
        e.s   = e.s & ((longint'(1) <<< w) - 1);
        e.cyc = c;
        return e;
    endfunction

    function automatic longint sum_a();
        longint s = 0;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 2; n++)
                s += (S_a[n][k] ? 1 : -1) * longint'($signed(H_a[k][n]));
        return s;
    endfunction

    function automatic longint sum_b();
        longint s = 0;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 3; n++)
                s += (S_b[n][k] ? 1 : -1) * longint'($signed(H_b[k][n]));
        return s;
    endfunction

    function automatic longint sum_c();
        longint s = 0;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 2; n++)
                s += (S_c[n][k] ? 1 : -1) * longint'($signed(H_c[k][n]));
        return s;
    endfunction

    function automatic longint sum_d();
        longint s = 0;
        for (int k = 0; k < 256; k++)
            for (int n = 0; n < 8; n++)
                s += (S_d[n][k] ? 1 : -1) * longint'($signed(H_d[k][n]));
        return s;
    endfunction

    // Raise start and score the sample it should produce (called just after a falling edge).
    task automatic go_a();
        start_a = 1'b1;
        q_a.push_back(mk(sum_a(), 0, 32, cyc + CA + 3));
    endtask

    task automatic go_d();
        start_d = 1'b1;
        q_d.push_back(mk(sum_d(), 4, 32, cyc + CD + 3));
    endtask

    // Scoreboard pops: value, overflow flag and arrival cycle; an unscored valid is an error.
    always @(negedge clk) begin
        if (vld_a === 1'b1) begin
            if (q_a.size() == 0) check("a_spurious_valid", 64'(vld_a), 64'd0);
            else begin
                e_a = q_a.pop_front();
                check("a_sample", 64'(smp_a), e_a.s);
                check("a_overflow", 64'(ovf_a), 64'(e_a.o));
                check("a_latency", 64'(cyc), 64'(e_a.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (vld_b === 1'b1) begin
            if (q_b.size() == 0) check("b_spurious_valid", 64'(vld_b), 64'd0);
            else begin
                e_b = q_b.pop_front();
                check("b_sample", 64'(smp_b), e_b.s);
                check("b_overflow", 64'(ovf_b), 64'(e_b.o));
                check("b_latency", 64'(cyc), 64'(e_b.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (vld_c === 1'b1) begin
            if (q_c.size() == 0) check("c_spurious_valid", 64'(vld_c), 64'd0);
            else begin
                e_c = q_c.pop_front();
                check("c_sample", 64'(smp_c), e_c.s);
                check("c_overflow", 64'(ovf_c), 64'(e_c.o));
                check("c_latency", 64'(cyc), 64'(e_c.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (vld_d === 1'b1) begin
            if (q_d.size() == 0) check("d_spurious_valid", 64'(vld_d), 64'd0);
            else begin
                e_d = q_d.pop_front();
                check("d_sample", 64'(smp_d), e_d.s);
                check("d_overflow", 64'(ovf_d), 64'(e_d.o));
                check("d_latency", 64'(cyc), 64'(e_d.cyc));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        S_a = '0; S_b = '0; S_c = '0; S_d = '0; H_d = '0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 2; n++) begin
                H_a[k][n] = 32'(k * 2 + n + 1);
                H_c[k][n] = 32'd100;
            end
            for (int n = 0; n < 3; n++) H_b[k][n] = 32'(k * 3 + n + 1);
        end

        // reset values
        repeat (3) @(negedge clk);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_valid_a", 64'(vld_a), 64'd0);
        check("rst_sample_a", 64'(smp_a), 64'd0);
        check("rst_overflow_a", 64'(ovf_a), 64'd0);
        check("rst_busy_d", 64'(busy_d), 64'd0);
        check("rst_valid_d", 64'(vld_d), 64'd0);
        check("rst_sample_d", 64'(smp_d), 64'd0);
        check("rst_overflow_d", 64'(ovf_d), 64'd0);
        @(negedge clk); reset = 1'b0;

        // all S=1: basic sum (A), padded groups (B), output range handling (C)
        S_a = '1; S_b = '1; S_c = '1;
        @(negedge clk);
        go_a();
        start_b = 1'b1; q_b.push_back(mk(sum_b(), 0, 32, cyc + CB + 3));
        start_c = 1'b1; q_c.push_back(mk(sum_c(), 0, 8, cyc + CA + 3));
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        check("busy_after_accept", 64'(busy_a), 64'd1);
        repeat (8) @(negedge clk);

        // all S=0, then only S[0][0]=1
        S_a = '0;
        @(negedge clk); go_a();
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);
        S_a[0][0] = 1'b1;
        @(negedge clk); go_a();
        @(negedge clk); start_a = 1'b0;
        check("busy_mid_accum", 64'(busy_a), 64'd1);
        repeat (6) @(negedge clk);

        // start pulsed during ACCUM is dropped; S changes after accept must not leak in
        S_a = 8'hC3;
        @(negedge clk); go_a();
        @(negedge clk); start_a = 1'b0; S_a = 8'h5A;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);

        // start held high: back-to-back samples every C+2 cycles, fresh snapshot each time
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            S_a = 8'($urandom);
            go_a();
            repeat (3) @(negedge clk);
        end
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);

        // reset at the second ACCUM cycle aborts without a sample
        S_a = 8'h3C;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_valid", 64'(vld_a), 64'd0);
        check("abort_sample", 64'(smp_a), 64'd0);
        check("abort_overflow", 64'(ovf_a), 64'd0);
        repeat (8) @(negedge clk);
        S_a = 8'h96;
        @(negedge clk); go_a();
        @(negedge clk); start_a = 1'b0;
        repeat (8) @(negedge clk);

        // default parameters with random coefficients and control bits, two samples
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 256; k++)
                for (int n = 0; n < 8; n++) begin
                    H_d[k][n] = (r == 0) ? $urandom() : 32'($signed(20'($urandom())));
                    S_d[n][k] = 1'($urandom_range(0, 1));
                end
            @(negedge clk); go_d();
            @(negedge clk); start_d = 1'b0;
            repeat (CD + 10) @(negedge clk);
        end

        // every scored sample must have arrived
        check("a_missing", 64'(q_a.size()), 64'd0);
        check("b_missing", 64'(q_b.size()), 64'd0);
        check("c_missing", 64'(q_c.size()), 64'd0);
        check("d_missing", 64'(q_d.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
